booth_mult_seq: RTL
===================

// Module: booth_mult_seq
// PURPOSE
//  Parametrised radix-2 Booth sequential multiplier with integrated controller.
//  Next generation of the 6-bit Booth datapath: WIDTH is generic, signed/unsigned
//  mode is selectable per operation, and the core has a start/busy/done handshake.
//  Operands and product use dedicated parallel ports; the product is held until
//  the next start. Sits under the arithmetic unit as its multiply engine.
// PARAMETERS
//  WIDTH  6  operand width in bits (>=2); product is 2*WIDTH bits
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous reset, active-low
//  start      in   1        request; sampled only in IDLE
//  signed_op  in   1        1: two's-complement operands, 0: unsigned; sampled with start
//  x_in       in   WIDTH    multiplicand; sampled with start
//  y_in       in   WIDTH    multiplier; sampled with start
//  busy       out  1        high in CALC and DONE
//  done       out  1        one-cycle pulse; product valid from this cycle on
//  product    out  2*WIDTH  result register
// BEHAVIOUR
//  Reset (rst=0, any time, incl. mid-operation): state=IDLE, A=0, X=0, Y=0,
//   y_m1=0, cnt=0, product=0, busy=0, done=0. No partial result is kept.
//  Internal widths: X and A are WIDTH+2 bits, Y is WIDTH+1 bits, cnt is
//   clog2(WIDTH+2) bits. Operand extension: signed_op=1 sign-extends,
//   signed_op=0 zero-extends. A never overflows, including A-X when x_in is
//   the most negative value.
//  Iteration count: N = WIDTH for signed_op=1, and N = WIDTH+1 for
//   signed_op=0. The extra step consumes the zero extension bit.
//  FSM states: IDLE, CALC, DONE.
//   IDLE: busy=0. On start=1 at edge k: load X=ext(x_in), Y=ext(y_in), A=0,
//    y_m1=0, cnt=0, latch N; next state=CALC. With start=0, state and product hold.
//   CALC: each edge applies one Booth step on pair {Y[0],y_m1}:
//    01 -> A'=A+X, 10 -> A'=A-X, 00/11 -> A'=A.
//    Then arithmetic right shift of {A',Y,y_m1} by 1: y_m1<=Y[0], Y<={A'[0],Y[WIDTH:1]},
//    A<={A'[MSB],A'[MSB:1]}. cnt<=cnt+1.
//    The edge that completes step N (edge k+N) loads product with the low 2*WIDTH
//    bits of {A,Y[WIDTH:1]} (signed) or {A,Y} (unsigned), each aligned so that
//    bit 0 is result bit 0. Next state=DONE.
//   DONE: done=1 for exactly one cycle; next state=IDLE. start is ignored here.
//  Latency: start sampled at edge k -> done high in the cycle after edge k+N.
//   Signed: WIDTH+1 cycles start-to-done. Unsigned: WIDTH+2 cycles.
//   Next start can be accepted at edge k+N+2. Throughput is one product per N+2 cycles.
//  start, x_in, y_in and signed_op are don't-care while busy. Changing them
//   mid-operation has no effect.
//  Product register changes only at the last CALC edge or on reset. It stays
//   stable from done onward until the next operation completes.
//  Outputs busy and done are decoded from registered state only. There is no
//   combinational path from inputs to outputs.
// TESTING
//  1 WIDTH=6, signed_op=1, x=-3 (6'h3D), y=5 -> done at cycle 7, product=12'hFF1 (-15).
//  2 WIDTH=6, signed, x=y=-32 (6'h20) -> product=12'h400 (1024). Checks the A-X
//    no-overflow path.
//  3 WIDTH=6, signed_op=0, x=y=63 -> done at cycle 8 (N=7), product=12'hF81 (3969).
//    Same bits with signed_op=1 -> 12'h001.
//  4 Start held high throughout a run, with x_in/y_in toggling while busy -> exactly
//    one done per N+2 cycles. Each product matches the operands captured at acceptance.
//  5 rst pulsed low in the 3rd CALC cycle -> busy=0, done=0, product=0 immediately
//    (async). A new start afterwards computes correctly.
//  6 WIDTH=8 and WIDTH=16, 2000 random operands in both modes -> product equals the
//    reference model x*y (2*WIDTH bits). done is never asserted twice per start.

Source files
------------

// File: rtl/booth_mult_seq.sv
// Radix-2 Booth sequential multiplier: start sampled in IDLE, done pulses N+1 cycles later (N=WIDTH signed, WIDTH+1 unsigned).
// No backpressure: inputs are ignored while busy, and the product holds until the next operation completes.
module booth_mult_seq #(
  parameter int WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_op,
  input  logic [WIDTH-1:0]     x_in,
  input  logic [WIDTH-1:0]     y_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int AW = WIDTH + 2;
  localparam int YW = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_S = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_U = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [AW-1:0]   a_q;
  logic [AW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic            y_m1;
  logic [CW-1:0]   cnt;
  logic            sgn_q;

  logic [AW-1:0]   x_ext;
  logic [YW-1:0]   y_ext;
  logic [AW-1:0]   a_sum;
  logic [AW-1:0]   a_nxt;
  logic [YW-1:0]   y_nxt;
  logic            last_step;
  logic [2*WIDTH-1:0] result;

  // Two guard bits on X/A keep A-X in range even for the most negative multiplicand.
  always_comb begin
    x_ext = signed_op ? {{2{x_in[WIDTH-1]}}, x_in} : {2'b00, x_in};
    y_ext = signed_op ? {y_in[WIDTH-1], y_in} : {1'b0, y_in};
  end

  always_comb begin
    a_sum = a_q;
    case ({y_q[0], y_m1})
      2'b01:   a_sum = a_q + x_q;
      2'b10:   a_sum = a_q - x_q;
      default: a_sum = a_q;
    endcase
  end

  always_comb begin
    a_nxt     = {a_sum[AW-1], a_sum[AW-1:1]};
    y_nxt     = {a_sum[0], y_q[WIDTH:1]};
    last_step = (cnt == (sgn_q ? LAST_S : LAST_U));
    // Signed runs leave the unconsumed sign-extension bit in Y[0]; unsigned runs consume all of Y.
    if (sgn_q)
      result = {a_nxt[WIDTH-1:0], y_nxt[WIDTH:1]};
    else
      result = {a_nxt[WIDTH-2:0], y_nxt};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      a_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      y_m1    <= 1'b0;
      cnt     <= '0;
      sgn_q   <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_q   <= x_ext;
            y_q   <= y_ext;
            a_q   <= '0;
            y_m1  <= 1'b0;
            cnt   <= '0;
            sgn_q <= signed_op;
            state <= CALC;
          end
        end
        CALC: begin
          a_q  <= a_nxt;
          y_q  <= y_nxt;
          y_m1 <= y_q[0];
          cnt  <= cnt + CW'(1);
          if (last_step) begin
            product <= result;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
